byte_lane_access_sequencer: RTL

//   Sequences byte/half/word accesses onto the four byte-wide sub-RAMs that form the 32-bit RAM.

---
 rtl/byte_lane_access_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/byte_lane_access_sequencer.sv
// Byte-lane access sequencer: maps byte/half/word requests onto four byte-wide
// sub-RAMs. Unaligned accesses that span two words complete in a single RAM
// access because each lane gets its own word index.
module byte_lane_access_sequencer #(
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [31:0]             req_wdata,
  output logic [4*(ADDR_W-2)-1:0] ram_addr,
  output logic [3:0]              ram_we,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err
);

  localparam int WW    = ADDR_W - 2;
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Rotate a 4-bit lane mask left: result[j] = v[(j-s)%4].
  function automatic logic [3:0] rotl4(input logic [3:0] v, input logic [1:0] s);
    logic [7:0] d;
    d = {v, v} << s;
    return d[7:4];
  endfunction

  // Rotate bytes left: lane j receives request byte (j-s)%4.
  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [1:0] s);
    logic [63:0] d;
    d = {v, v} << {s, 3'b000};
    return d[63:32];
  endfunction

  // Rotate bytes right: request byte k receives lane (k+s)%4.
  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [1:0] s);
    logic [63:0] d;
    d = {v, v} >> {s, 3'b000};
    return d[31:0];
  endfunction

  // Expand a 4-bit byte mask to a 32-bit bit mask.
  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_t           state, state_next;
  logic [1:0]       sh_r;
  logic [3:0]       mask_r;
  logic             we_r;
  logic [CNT_W-1:0] cnt_r;
  logic             first_r;
  logic [31:0]      hold_r;

  logic             acc_s;
  logic [1:0]       sh_s;
  logic [WW-1:0]    w_s;
  logic [3:0]       mask_s;
  logic [3:0]       lane_en_s;
  logic [3:0]       lo_lanes_s;
  logic             err_s;
  logic [4*WW-1:0]  lane_addr_s;
  logic [31:0]      lane_wdata_s;
  logic [31:0]      rd_fmt_s;

  // Decode the incoming request: lane enables, per-lane addresses, error check.
  always_comb begin
    acc_s        = (state == IDLE) && req_valid;
    sh_s         = req_addr[1:0];
    w_s          = req_addr[ADDR_W-1:2];
    case (req_size)
      2'b00:   mask_s = 4'b0001;
      2'b01:   mask_s = 4'b0011;
      2'b10:   mask_s = 4'b1111;
      default: mask_s = 4'b0000;
    endcase
    lane_en_s    = rotl4(mask_s, sh_s);
    lo_lanes_s   = (4'd1 << sh_s) - 4'd1;
    err_s        = (req_size == 2'b11) || ((&w_s) && (|(lane_en_s & lo_lanes_s)));
    lane_wdata_s = rotl32(req_wdata, sh_s);
    lane_addr_s  = '0;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) < sh_s) begin
        lane_addr_s[j*WW +: WW] = w_s + WW'(1);
      end else begin
        lane_addr_s[j*WW +: WW] = w_s;
      end
    end
  end

  // Lane-ordered read data back into request order, unused bytes zeroed.
  always_comb begin
    rd_fmt_s = rotr32(ram_rdata, sh_r) & byte_expand(mask_r);
  end

  // Read data passes through on the first response cycle, then comes from the hold register.
  always_comb begin
    if (first_r) begin
      rsp_rdata = rd_fmt_s;
    end else begin
      rsp_rdata = hold_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (acc_s) begin
          if (err_s) begin
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (we_r || (RD_LAT == 1)) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, registered RAM drive, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= 32'h0000_0000;
      sh_r      <= 2'b00;
      mask_r    <= 4'b0000;
      we_r      <= 1'b0;
      cnt_r     <= '0;
      first_r   <= 1'b0;
      hold_r    <= 32'h0000_0000;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      first_r   <= (state_next == RESP) && ((state == ISSUE) || (state == WAIT)) && !we_r;
      ram_we    <= 4'b0000;

      if (acc_s) begin
        sh_r    <= sh_s;
        mask_r  <= mask_s;
        we_r    <= req_we;
        rsp_err <= err_s;
        hold_r  <= 32'h0000_0000;
        if (!err_s) begin
          ram_addr  <= lane_addr_s;
          ram_wdata <= lane_wdata_s;
          ram_we    <= req_we ? lane_en_s : 4'b0000;
        end
      end

      if (state == ISSUE) begin
        cnt_r <= CNT_W'(RD_LAT - 1);
      end else if (state == WAIT) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end

      if (first_r) begin
        hold_r <= rd_fmt_s;
      end

      if ((state == RESP) && rsp_ready) begin
        rsp_err <= 1'b0;
        hold_r  <= 32'h0000_0000;
      end
    end
  end

endmodule
